// File: rtl/irda_sir_encoder.sv
// IrDA SIR transmit encoder: UART framing with RZI 3/16-bit pulses for zero bits.
// Optional fixed 1.6 us pulse width: define IRDA_SIR_PULSE_1P6_EN.
module irda_sir_encoder #(
    parameter int PULSE_POS     = 7,
    parameter int PULSE_1P6_CYC = 16
) (
    input  logic       clk,
    input  logic       wb_rst_n,
    input  logic       sir_en,
    input  logic       baud16_en,
    input  logic       parity_en,
    input  logic       parity_even,
    input  logic       stop2,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       sir_enc_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    if (PULSE_POS < 1 || PULSE_POS > 13 || PULSE_1P6_CYC < 1) begin : g_bad_cfg
        $error("irda_sir_encoder: illegal PULSE_POS or PULSE_1P6_CYC");
    end

    state_t     r_state, w_state_nxt;
    logic [3:0] r_sub, w_sub_nxt;
    logic [2:0] r_bit, w_bit_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic       r_par, w_par_nxt;
    logic       r_par_en, w_par_en_nxt;
    logic       r_stop2, w_stop2_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_done, w_done_nxt;
    logic       r_enc, w_enc_nxt;
    logic       w_xfer;
    logic       w_bit_end;
    logic       w_cur_bit;
    logic       w_in_win;

`ifdef IRDA_SIR_PULSE_1P6_EN
    localparam int PCW = $clog2(PULSE_1P6_CYC + 1);
    logic [PCW-1:0] r_pcnt, w_pcnt_nxt;
`endif

    assign tx_ready  = (r_state == S_IDLE) & sir_en & wb_rst_n;
    assign tx_busy   = r_busy;
    assign tx_done   = r_done;
    assign sir_enc_o = r_enc;

    assign w_xfer    = tx_valid & tx_ready;
    assign w_bit_end = baud16_en & (r_sub == 4'd15) & (r_state != S_IDLE);
    assign w_in_win  = (r_sub >= 4'(PULSE_POS)) && (r_sub <= 4'(PULSE_POS + 2));

    always_comb begin
        w_cur_bit = 1'b1;
        case (r_state)
            S_START:  w_cur_bit = 1'b0;
            S_DATA:   w_cur_bit = r_shift[0];
            S_PARITY: w_cur_bit = r_par;
            default:  w_cur_bit = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sub_nxt    = r_sub;
        w_bit_nxt    = r_bit;
        w_shift_nxt  = r_shift;
        w_par_nxt    = r_par;
        w_par_en_nxt = r_par_en;
        w_stop2_nxt  = r_stop2;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
`ifdef IRDA_SIR_PULSE_1P6_EN
        w_pcnt_nxt = r_pcnt;
        w_enc_nxt  = (r_pcnt != '0);
        if (r_pcnt != '0)
            w_pcnt_nxt = r_pcnt - 1'b1;
        // Load on the strobe that moves the sub-counter onto PULSE_POS
        if ((r_state != S_IDLE) && baud16_en && !w_cur_bit
            && (r_sub == 4'(PULSE_POS - 1)))
            w_pcnt_nxt = PCW'(PULSE_1P6_CYC);
        if (w_bit_end) begin
            w_pcnt_nxt = '0;
            w_enc_nxt  = 1'b0;
        end
`else
        w_enc_nxt = (r_state != S_IDLE) & ~w_cur_bit & w_in_win;
`endif
        if (r_state == S_IDLE) begin
            if (w_xfer) begin
                w_shift_nxt  = tx_data;
                w_par_nxt    = parity_even ? ^tx_data : ~^tx_data;
                w_par_en_nxt = parity_en;
                w_stop2_nxt  = stop2;
                w_state_nxt  = S_START;
                w_sub_nxt    = 4'd0;
                w_bit_nxt    = 3'd0;
                w_busy_nxt   = 1'b1;
            end
        end else begin
            if (baud16_en)
                w_sub_nxt = r_sub + 4'd1;
            if (w_bit_end) begin
                case (r_state)
                    S_START: begin
                        w_state_nxt = S_DATA;
                        w_bit_nxt   = 3'd0;
                    end
                    S_DATA: begin
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        if (r_bit == 3'd7) begin
                            w_bit_nxt   = 3'd0;
                            w_state_nxt = r_par_en ? S_PARITY : S_STOP;
                        end else begin
                            w_bit_nxt = r_bit + 3'd1;
                        end
                    end
                    S_PARITY: w_state_nxt = S_STOP;
                    S_STOP: begin
                        if (r_stop2 && (r_bit == 3'd0)) begin
                            w_bit_nxt = 3'd1;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_bit_nxt   = 3'd0;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                        end
                    end
                    default: w_state_nxt = S_IDLE;
                endcase
            end
        end
        // Abort silently: the in-flight byte is dropped without tx_done
        if (!sir_en) begin
            w_state_nxt = S_IDLE;
            w_sub_nxt   = 4'd0;
            w_bit_nxt   = 3'd0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
            w_enc_nxt   = 1'b0;
`ifdef IRDA_SIR_PULSE_1P6_EN
            w_pcnt_nxt = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state  <= S_IDLE;
            r_sub    <= 4'd0;
            r_bit    <= 3'd0;
            r_shift  <= 8'd0;
            r_par    <= 1'b0;
            r_par_en <= 1'b0;
            r_stop2  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_enc    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sub    <= w_sub_nxt;
            r_bit    <= w_bit_nxt;
            r_shift  <= w_shift_nxt;
            r_par    <= w_par_nxt;
            r_par_en <= w_par_en_nxt;
            r_stop2  <= w_stop2_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_enc    <= w_enc_nxt;
        end
    end

`ifdef IRDA_SIR_PULSE_1P6_EN
    always_ff @(posedge clk or negedge wb_rst_n) begin
        if (!wb_rst_n)
            r_pcnt <= '0;
        else
            r_pcnt <= w_pcnt_nxt;
    end
`endif

endmodule

// File: tb/tb_irda_sir_encoder.sv
// Directed bench for irda_sir_encoder: pulse count/width/offset, frame length,
// back-to-back frames, abort and asynchronous reset.
module tb_irda_sir_encoder;

    logic       clk;
    logic       wb_rst_n;
    logic       sir_en;
    logic       baud16_en;
    logic       parity_en;
    logic       parity_even;
    logic       stop2;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       sir_enc_o;

    int checks = 0;
    int errors = 0;

    int baud_per = 4;
    int bcnt     = 0;
    int exp_w    = 12;
    int ecnt     = 0;
    int t0       = 0;
    int strobes  = 0;
    int pulses   = 0;
    int pw       = 0;
    int rise_off = -1;
    int rise_pend = 0;
    int done_cnt = 0;
    int done_edge = 0;
    int xfer_edge = 0;
    int fr_str   = 0;
    int fr_pul   = 0;

    irda_sir_encoder #(
        .PULSE_POS     (7),
        .PULSE_1P6_CYC (16)
    ) dut (
        .clk         (clk),
        .wb_rst_n    (wb_rst_n),
        .sir_en      (sir_en),
        .baud16_en   (baud16_en),
        .parity_en   (parity_en),
        .parity_even (parity_even),
        .stop2       (stop2),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .sir_enc_o   (sir_enc_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic xfer;
        xfer = tx_valid & tx_ready;
        if (xfer) begin
            strobes   = 0;
            pulses    = 0;
            rise_pend = 1;
        end else if (baud16_en) begin
            strobes++;
        end
        @(posedge clk);
        #1;
        ecnt++;
        if (xfer) begin
            t0        = ecnt;
            xfer_edge = ecnt;
        end
        if (sir_enc_o) begin
            if (pw == 0 && rise_pend != 0) begin
                rise_off  = ecnt - t0;
                rise_pend = 0;
            end
            pw++;
        end else if (pw != 0) begin
            chk("pulse_width", pw, exp_w);
            pulses++;
            pw = 0;
        end
        if (tx_done) begin
            done_cnt++;
            done_edge = ecnt;
            fr_str    = strobes;
            fr_pul    = pulses;
        end
        bcnt      = (bcnt + 1) % baud_per;
        baud16_en = (bcnt == 0);
    endtask

    task automatic send(input logic [7:0] d, input logic pe,
                        input logic pev, input logic s2, input logic hold);
        int n;
        n = 0;
        while (!tx_ready && n < 2000) begin
            tick();
            n++;
        end
        if (!tx_ready)
            chk("ready_timeout", 0, 1);
        tx_data     = d;
        parity_en   = pe;
        parity_even = pev;
        stop2       = s2;
        tx_valid    = 1'b1;
        bcnt        = 0;
        baud16_en   = 1'b1;
        tick();
        if (!hold)
            tx_valid = 1'b0;
    endtask

    task automatic wait_done();
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < 20000) begin
            tick();
            n++;
        end
        chk("done_timeout", int'(done_cnt != start), 1);
        chk("busy_at_done", int'(tx_busy), 0);
    endtask

    task automatic frame(input string tag, input logic [7:0] d,
                         input logic pe, input logic pev, input logic s2,
                         input int np, input int ns);
        send(d, pe, pev, s2, 1'b0);
        wait_done();
        chk({tag, "_pulses"}, fr_pul, np);
        chk({tag, "_strobes"}, fr_str, ns);
        chk({tag, "_rise"}, rise_off, 29);
        tick();
        chk({tag, "_done_1clk"}, int'(tx_done), 0);
        chk({tag, "_ready"}, int'(tx_ready), 1);
    endtask

    initial begin
        int dc;
        int n;
        clk         = 1'b0;
        wb_rst_n    = 1'b1;
        sir_en      = 1'b0;
        baud16_en   = 1'b0;
        parity_en   = 1'b0;
        parity_even = 1'b0;
        stop2       = 1'b0;
        tx_data     = 8'h00;
        tx_valid    = 1'b0;
`ifdef IRDA_SIR_PULSE_1P6_EN
        exp_w = 16;
`else
        exp_w = 3 * baud_per;
`endif
        #2 wb_rst_n = 1'b0;
        #1;
        chk("rst_enc", int'(sir_enc_o), 0);
        chk("rst_busy", int'(tx_busy), 0);
        chk("rst_done", int'(tx_done), 0);
        sir_en = 1'b1;
        #1;
        chk("rst_ready", int'(tx_ready), 0);
        repeat (3) tick();
        wb_rst_n = 1'b1;
        #1;
        chk("post_rst_ready", int'(tx_ready), 1);

        frame("f55", 8'h55, 1'b0, 1'b0, 1'b0, 5, 160);
        frame("fFF_odd", 8'hFF, 1'b1, 1'b0, 1'b0, 1, 176);

        send(8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
        tx_data = 8'hA5;
        wait_done();
        chk("f00_pulses", fr_pul, 10);
        chk("f00_strobes", fr_str, 192);
        chk("f00_rise", rise_off, 29);
        tick();
        chk("held_accept", xfer_edge, done_edge + 1);
        tx_valid = 1'b0;
        wait_done();
        chk("fA5_pulses", fr_pul, 6);
        chk("fA5_strobes", fr_str, 192);
        tick();

        send(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (strobes < 50 && n < 2000) begin
            tick();
            n++;
        end
        chk("abort_reach", strobes, 50);
        sir_en = 1'b0;
        dc = done_cnt;
        tick();
        chk("abort_enc", int'(sir_enc_o), 0);
        chk("abort_busy", int'(tx_busy), 0);
        chk("abort_ready", int'(tx_ready), 0);
        repeat (20) tick();
        chk("abort_no_done", done_cnt, dc);
        chk("abort_enc_idle", int'(sir_enc_o), 0);
        sir_en = 1'b1;
        #1;
        chk("abort_ready_back", int'(tx_ready), 1);
        frame("f55_after", 8'h55, 1'b0, 1'b0, 1'b0, 5, 160);

        send(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!sir_enc_o && n < 2000) begin
            tick();
            n++;
        end
        tick();
        chk("pre_rst_pulse", int'(sir_enc_o), 1);
        wb_rst_n = 1'b0;
        #1;
        chk("arst_enc", int'(sir_enc_o), 0);
        chk("arst_busy", int'(tx_busy), 0);
        chk("arst_ready", int'(tx_ready), 0);
        pw = 0;
        repeat (3) tick();
        wb_rst_n = 1'b1;
        #1;
        chk("arst_ready_back", int'(tx_ready), 1);
        frame("fFF_post", 8'hFF, 1'b0, 1'b0, 1'b0, 1, 160);

`ifdef IRDA_SIR_PULSE_1P6_EN
        baud_per = 64;
        frame("f00_1p6", 8'h00, 1'b0, 1'b0, 1'b0, 9, 160);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
